// File: rtl/king_escape_scan_if.sv
// Handshake between the escape scanner and the single shared move checker.
interface king_escape_scan_if;
  logic        req;
  logic [13:0] move;
  logic        ack;
  logic        allow;
  logic        attacked;

  modport master (output req, move, input ack, allow, attacked);
  modport slave  (input req, move, output ack, allow, attacked);
endinterface

// File: rtl/king_escape_scan.sv
// Walks the eight king-neighbour squares through one shared move checker and
// turns the resulting escape mask into a continue/win/draw verdict.
module king_escape_scan #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               side,
  input  logic [5:0]         kingPosition,
  input  logic [255:0]       board,
  input  logic               king_in_check,
  input  logic               other_moves,
  king_escape_scan_if.master chk,
  output logic               busy,
  output logic               done,
  output logic [7:0]         escape_mask,
  output logic [1:0]         winState,
  output logic               timeout_err
);

  localparam logic [3:0] TIMER_LAST = 4'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, CLASSIFY, REQ, ADVANCE, VERDICT} state_t;

  state_t            state, next_state;
  logic              side_q, check_q, other_q;
  logic [5:0]        king_q;
  logic [2:0]        index;
  logic [3:0]        timer;
  logic signed [3:0] dr, dc, row_n, col_n;
  logic              on_board, skip;
  logic [5:0]        dest;
  logic [3:0]        dest_piece;
  logic [1:0]        verdict;

  always_comb begin
    dr = 4'sd0;
    dc = 4'sd0;
    case (index)
      3'd0: begin dr =  4'sd1; dc = -4'sd1; end
      3'd1: begin dr =  4'sd1; dc =  4'sd0; end
      3'd2: begin dr =  4'sd1; dc =  4'sd1; end
      3'd3: begin dr =  4'sd0; dc = -4'sd1; end
      3'd4: begin dr =  4'sd0; dc =  4'sd1; end
      3'd5: begin dr = -4'sd1; dc = -4'sd1; end
      3'd6: begin dr = -4'sd1; dc =  4'sd0; end
      3'd7: begin dr = -4'sd1; dc =  4'sd1; end
      default: begin dr = 4'sd0; dc = 4'sd0; end
    endcase
  end

  assign row_n = $signed({1'b0, king_q[5:3]}) + dr;
  assign col_n = $signed({1'b0, king_q[2:0]}) + dc;
  // Stepping off either edge lands on -1 or 8, both of which have bit 3 set.
  assign on_board   = ~row_n[3] & ~col_n[3];
  assign dest       = {row_n[2:0], col_n[2:0]};
  assign dest_piece = board[{dest, 2'b00} +: 4];
  assign skip       = ~on_board | ((dest_piece != 4'h0) & (dest_piece[3] == side_q));
  assign chk.move   = {side_q, 1'b0, dest, king_q};

  always_comb begin
    verdict = 2'b00;
    if ((escape_mask == 8'h00) && !other_q)
      verdict = check_q ? (side_q ? 2'b01 : 2'b10) : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = (state != IDLE);
    done       = (state == VERDICT);
    chk.req    = (state == REQ);
    case (state)
      IDLE:     if (start) next_state = CLASSIFY;
      CLASSIFY: next_state = skip ? ADVANCE : REQ;
      REQ:      if (chk.ack || (timer == TIMER_LAST)) next_state = ADVANCE;
      ADVANCE:  next_state = (index == 3'd7) ? VERDICT : CLASSIFY;
      VERDICT:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  // Latched scan context, per-square results and the ack timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      side_q      <= 1'b0;
      check_q     <= 1'b0;
      other_q     <= 1'b0;
      king_q      <= 6'd0;
      index       <= 3'd0;
      timer       <= 4'd0;
      escape_mask <= 8'h00;
      winState    <= 2'b00;
      timeout_err <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          side_q      <= side;
          check_q     <= king_in_check;
          other_q     <= other_moves;
          king_q      <= kingPosition;
          index       <= 3'd0;
          timer       <= 4'd0;
          escape_mask <= 8'h00;
          winState    <= 2'b00;
          timeout_err <= 1'b0;
        end
        CLASSIFY: if (skip) escape_mask[index] <= 1'b0;
        REQ: begin
          if (chk.ack) begin
            escape_mask[index] <= chk.allow & ~chk.attacked;
          end else if (timer == TIMER_LAST) begin
            escape_mask[index] <= 1'b0;
            timeout_err        <= 1'b1;
          end else begin
            timer <= timer + 4'd1;
          end
        end
        ADVANCE: begin
          timer <= 4'd0;
          if (index == 3'd7) winState <= verdict;
          else               index    <= index + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_king_escape_scan.sv
// Directed and randomized escape scans checked against a square-by-square model of the
// neighbour walk, with a behavioural checker answering requests on the interface.
module tb_king_escape_scan;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         side = 1'b0;
  logic [5:0]   kingPosition = 6'd0;
  logic [255:0] board = '0;
  logic         king_in_check = 1'b0;
  logic         other_moves = 1'b0;
  logic         busy, done, timeout_err;
  logic [7:0]   escape_mask;
  logic [1:0]   winState;

  always #5 clk = ~clk;

  king_escape_scan_if chk ();

  king_escape_scan #(.TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .reset(reset), .start(start), .side(side), .kingPosition(kingPosition),
    .board(board), .king_in_check(king_in_check), .other_moves(other_moves), .chk(chk),
    .busy(busy), .done(done), .escape_mask(escape_mask), .winState(winState),
    .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;

  logic [3:0]  board_arr [64];
  bit          allow_tab [64];
  bit          attacked_tab [64];
  bit          withhold_tab [64];
  int          delay_tab [64];
  int          age = 0;
  int          req_cycles = 0;
  int          done_count = 0;
  logic [13:0] req_log [$];
  logic [13:0] exp_log [$];
  logic        resp_ack = 1'b0, resp_allow = 1'b0, resp_attacked = 1'b0;
  logic [5:0]  resp_dest;

  assign chk.ack      = resp_ack;
  assign chk.allow    = resp_allow;
  assign chk.attacked = resp_attacked;

  // Checker stand-in: answers after a per-square delay, never for withheld squares, noise otherwise.
  always @(negedge clk) begin
    if (done === 1'b1) done_count++;
    if (chk.req === 1'b1) begin
      resp_dest = chk.move[11:6];
      if (age == 0) req_log.push_back(chk.move);
      req_cycles++;
      if (!withhold_tab[resp_dest] && age >= delay_tab[resp_dest]) begin
        resp_ack      = 1'b1;
        resp_allow    = allow_tab[resp_dest];
        resp_attacked = attacked_tab[resp_dest];
      end else begin
        resp_ack      = 1'b0;
        resp_allow    = 1'($urandom);
        resp_attacked = 1'($urandom);
      end
      age++;
    end else begin
      age           = 0;
      resp_ack      = 1'($urandom);
      resp_allow    = 1'($urandom);
      resp_attacked = 1'($urandom);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearBoard();
    for (int q = 0; q < 64; q++) board_arr[q] = 4'h0;
  endtask

  task automatic setPolicy(input bit al, input bit at, input int dl, input bit wh);
    for (int q = 0; q < 64; q++) begin
      allow_tab[q] = al; attacked_tab[q] = at; delay_tab[q] = dl; withhold_tab[q] = wh;
    end
  endtask

  task automatic loadBoard();
    for (int q = 0; q < 64; q++) board[4*q +: 4] = board_arr[q];
  endtask

  // Expected results from plain row/column arithmetic over the eight king steps.
  task automatic modelScan(input bit s, input logic [5:0] kp, input bit kic, input bit om,
                           output logic [7:0] emask, output logic [1:0] ewin,
                           output int ecycles, output int ereq, output bit eto);
    int dr [8] = '{1, 1, 1, 0, 0, -1, -1, -1};
    int dc [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
    int kpi, r, c, sq;
    kpi = int'(kp);
    emask = 8'h00; ewin = 2'b00; ecycles = 1; ereq = 0; eto = 0;
    exp_log.delete();
    for (int i = 0; i < 8; i++) begin
      r = kpi / 8 + dr[i];
      c = kpi % 8 + dc[i];
      if (r < 0 || r > 7 || c < 0 || c > 7) begin ecycles += 2; continue; end
      sq = r * 8 + c;
      if (board_arr[sq] != 4'h0 && board_arr[sq][3] == s) begin ecycles += 2; continue; end
      exp_log.push_back({s, 1'b0, 6'(sq), kp});
      if (withhold_tab[sq]) begin
        ecycles += 17; ereq += 15; eto = 1;
      end else begin
        ecycles += 3 + delay_tab[sq];
        ereq += 1 + delay_tab[sq];
        emask[i] = allow_tab[sq] && !attacked_tab[sq];
      end
    end
    if (emask == 8'h00 && !om) ewin = kic ? (s ? 2'b01 : 2'b10) : 2'b11;
  endtask

  task automatic applyStimulus(input string tag, input bit s, input logic [5:0] kp,
                               input bit kic, input bit om, input bit poke);
    logic [7:0] emask;
    logic [1:0] ewin;
    int ecycles, ereq, cycles, done_base;
    bit eto, busy_ok, to_clear, log_ok;
    modelScan(s, kp, kic, om, emask, ewin, ecycles, ereq, eto);
    loadBoard();
    side = s; kingPosition = kp; king_in_check = kic; other_moves = om;
    req_log.delete();
    req_cycles = 0;
    done_base = done_count;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0; busy_ok = 1; to_clear = 0;
    while (cycles < 400) begin
      @(negedge clk); #1;
      cycles++;
      start = poke && (cycles == 5);
      if (busy !== 1'b1) busy_ok = 0;
      if (cycles == 1) to_clear = (timeout_err === 1'b0);
      if (done === 1'b1) break;
    end
    start = 1'b0;
    checkOutput({tag, ".cycles"}, cycles, ecycles);
    checkOutput({tag, ".mask"}, escape_mask, emask);
    checkOutput({tag, ".win"}, winState, ewin);
    checkOutput({tag, ".timeout"}, timeout_err, eto);
    checkOutput({tag, ".busy_run"}, busy_ok, 1);
    checkOutput({tag, ".to_cleared"}, to_clear, 1);
    @(negedge clk); #1;
    checkOutput({tag, ".busy_after"}, busy, 0);
    checkOutput({tag, ".done_after"}, done, 0);
    checkOutput({tag, ".mask_held"}, escape_mask, emask);
    checkOutput({tag, ".done_pulses"}, done_count - done_base, 1);
    checkOutput({tag, ".req_cycles"}, req_cycles, ereq);
    log_ok = (req_log.size() == exp_log.size());
    if (log_ok) foreach (exp_log[k]) if (req_log[k] !== exp_log[k]) log_ok = 0;
    checkOutput({tag, ".req_moves"}, log_ok, 1);
  endtask

  initial begin
    int guard, done_base;
    bit found32;
    logic [5:0] kp;
    bit s;

    clearBoard();
    setPolicy(0, 0, 0, 0);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.mask", escape_mask, 0);
    checkOutput("reset.win", winState, 0);
    checkOutput("reset.timeout", timeout_err, 0);
    checkOutput("reset.req", chk.req, 0);
    reset = 1'b0;
    @(negedge clk); #1;

    $display("[TB] white king e1 on empty board");
    clearBoard(); board_arr[4] = 4'h6; setPolicy(1, 0, 0, 0);
    applyStimulus("t1", 0, 6'd4, 0, 1, 0);
    checkOutput("t1.spec_mask", escape_mask, 8'h1F);

    $display("[TB] black king a8 mated");
    clearBoard(); board_arr[56] = 4'hE; setPolicy(1, 1, 0, 0);
    applyStimulus("t2", 1, 6'd56, 1, 0, 0);
    checkOutput("t2.spec_win", winState, 2'b01);

    $display("[TB] white king h4 stalemate");
    clearBoard(); board_arr[31] = 4'h6; setPolicy(0, 0, 1, 0);
    applyStimulus("t3", 0, 6'd31, 0, 0, 0);
    checkOutput("t3.spec_win", winState, 2'b11);
    found32 = 0;
    foreach (req_log[k]) if (req_log[k][11:6] == 6'd32) found32 = 1;
    checkOutput("t3.no_wrap", found32, 0);

    $display("[TB] king d4 boxed in by own pieces");
    clearBoard(); board_arr[27] = 4'h6; setPolicy(1, 0, 0, 0);
    board_arr[18] = 4'h1; board_arr[19] = 4'h2; board_arr[20] = 4'h3; board_arr[26] = 4'h4;
    board_arr[28] = 4'h5; board_arr[34] = 4'h1; board_arr[35] = 4'h1; board_arr[36] = 4'h2;
    applyStimulus("t4", 0, 6'd27, 0, 1, 0);
    checkOutput("t4.spec_reqs", req_cycles, 0);

    $display("[TB] ack withheld on neighbour 1");
    clearBoard(); board_arr[27] = 4'h6; setPolicy(1, 0, 0, 0); withhold_tab[35] = 1;
    applyStimulus("t5", 0, 6'd27, 0, 1, 0);
    checkOutput("t5.spec_timeout", timeout_err, 1);
    checkOutput("t5.spec_mask1", escape_mask[1], 0);
    withhold_tab[35] = 0;
    applyStimulus("t5b", 0, 6'd27, 0, 1, 0);

    $display("[TB] randomized scans");
    for (int n = 0; n < 16; n++) begin
      kp = 6'($urandom_range(0, 63));
      s  = 1'($urandom_range(0, 1));
      for (int q = 0; q < 64; q++) begin
        board_arr[q]    = ($urandom_range(0, 1) == 0) ? 4'h0 : {1'($urandom_range(0, 1)), 3'($urandom_range(1, 6))};
        allow_tab[q]    = 1'($urandom_range(0, 1));
        attacked_tab[q] = 1'($urandom_range(0, 1));
        delay_tab[q]    = $urandom_range(0, 3);
        withhold_tab[q] = ($urandom_range(0, 9) == 0);
      end
      board_arr[kp] = {s, 3'd6};
      applyStimulus($sformatf("rnd%0d", n), s, kp, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), n[0]);
    end

    $display("[TB] reset during request of neighbour 3");
    clearBoard(); board_arr[27] = 4'h6; setPolicy(1, 0, 0, 0); withhold_tab[26] = 1;
    loadBoard();
    side = 0; kingPosition = 6'd27; king_in_check = 0; other_moves = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    guard = 0;
    while (!(chk.req === 1'b1 && chk.move[11:6] == 6'd26) && guard < 100) begin
      @(negedge clk); #1;
      guard++;
    end
    checkOutput("t6.reached_req3", guard < 100, 1);
    done_base = done_count;
    reset = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6.req", chk.req, 0);
    checkOutput("t6.busy", busy, 0);
    checkOutput("t6.mask", escape_mask, 0);
    checkOutput("t6.win", winState, 0);
    checkOutput("t6.done", done, 0);
    reset = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);
    #1;
    checkOutput("t6.no_done", done_count - done_base, 0);
    checkOutput("t6.idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
